// File: rtl/regfile_write_buffer.sv
// Write-back buffer in front of the 32x32 register file: queues write requests in a
// circular FIFO, drains one per cycle and bypasses pending values to both read ports.
module regfile_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       drain_stall,
    output logic                       wr_ena,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    input  logic [ADDR_W-1:0]          rd_addr0,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [DATA_W-1:0]          rf_data0,
    input  logic [DATA_W-1:0]          rf_data1,
    output logic [DATA_W-1:0]          rd_data0,
    output logic [DATA_W-1:0]          rd_data1,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              push, pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pending  = count_q;
    assign in_ready = rst && !full;

    // Writes to x0 complete the handshake but are never stored.
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign wr_ena   = !empty && !drain_stall;
    assign pop      = wr_ena;
    assign wr_addr  = wr_ena ? addr_mem[head_q] : '0;
    assign wr_data  = wr_ena ? data_mem[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= in_addr;
            data_mem[tail_q] <= in_data;
        end
    end

    // Walk oldest to newest so the newest matching entry is the last one assigned.
    always_comb begin
        logic [PW-1:0] idx;
        rd_data0 = rf_data0;
        rd_data1 = rf_data1;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (addr_mem[idx] == rd_addr0) rd_data0 = data_mem[idx];
                if (addr_mem[idx] == rd_addr1) rd_data1 = data_mem[idx];
            end
        end
        if (rd_addr0 == '0) rd_data0 = '0;
        if (rd_addr1 == '0) rd_data1 = '0;
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer; a negedge monitor checks every drained write
// against a scoreboard queue filled as requests are accepted.
module tb_regfile_write_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_stall;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rf_data0, rf_data1, rd_data0, rd_data1;
    logic [2:0]  pending;
    logic        full, empty;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .drain_stall(drain_stall),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rf_data0(rf_data0), .rf_data1(rf_data1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .pending(pending), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; records it for the monitor unless it targets x0.
    task automatic push(input logic [4:0] a, input logic [31:0] d);
        int k;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push timeout: in_ready still 0 for x%0d", a);
        end else if (a != 5'd0) begin
            sb.push_back({a, d});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (!empty && k < 30) begin
            step();
            k++;
        end
        chk("drained to empty", 64'(empty), 64'd1);
        chk("scoreboard consumed", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (wr_ena === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected write: got x%0d=0x%0h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                chk("drain order", {27'd0, wr_addr, wr_data}, {27'd0, e.a, e.d});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; drain_stall = 1'b0;
        rd_addr0 = 5'd3; rd_addr1 = 5'd0; rf_data0 = 32'h1234; rf_data1 = 32'hFFFF;

        // Reset asserted mid-cycle
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset pending", 64'(pending), 64'd0);
        chk("reset empty", 64'(empty), 64'd1);
        chk("reset full", 64'(full), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset wr_ena", 64'(wr_ena), 64'd0);
        chk("reset wr_addr", 64'(wr_addr), 64'd0);
        chk("reset wr_data", 64'(wr_data), 64'd0);
        chk("reset rd_data0", 64'(rd_data0), 64'h1234);
        chk("reset rd_data1 x0", 64'(rd_data1), 64'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("in_ready after release", 64'(in_ready), 64'd1);

        // Single write to x5
        rd_addr0 = 5'd5; rf_data0 = 32'd0;
        push(5'd5, 32'hDEADBEEF);
        chk("single wr_ena", 64'(wr_ena), 64'd1);
        chk("single wr_addr", 64'(wr_addr), 64'd5);
        chk("single wr_data", 64'(wr_data), 64'hDEADBEEF);
        chk("single bypass", 64'(rd_data0), 64'hDEADBEEF);
        chk("single pending", 64'(pending), 64'd1);
        step();
        chk("single drained", 64'(pending), 64'd0);
        chk("rf after drain", 64'(rd_data0), 64'd0);

        // x0 discard
        rd_addr1 = 5'd0; rf_data1 = 32'hFFFF;
        chk("x0 in_ready", 64'(in_ready), 64'd1);
        push(5'd0, 32'h12345678);
        chk("x0 pending", 64'(pending), 64'd0);
        chk("x0 wr_ena", 64'(wr_ena), 64'd0);
        chk("x0 rd_data1", 64'(rd_data1), 64'd0);
        step();
        chk("x0 wr_ena later", 64'(wr_ena), 64'd0);

        // Fill under stall, then release with a fifth request waiting
        drain_stall = 1'b1;
        rd_addr1 = 5'd3;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
        chk("fill full", 64'(full), 64'd1);
        chk("fill in_ready", 64'(in_ready), 64'd0);
        chk("fill pending", 64'(pending), 64'd4);
        chk("fill bypass x3", 64'(rd_data1), 64'h33);
        drain_stall = 1'b0;
        push(5'd5, 32'h55);
        wait_empty();

        // Newest entry wins the bypass
        drain_stall = 1'b1;
        rd_addr0 = 5'd7; rf_data0 = 32'hF;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        chk("newest wins", 64'(rd_data0), 64'hB);
        drain_stall = 1'b0;
        step();
        chk("newest after pop1", 64'(rd_data0), 64'hB);
        step();
        chk("rf after pop2", 64'(rd_data0), 64'hF);
        chk("pending after pop2", 64'(pending), 64'd0);

        // Simultaneous push/pop at occupancy 2, wrapping the pointers
        drain_stall = 1'b1;
        push(5'd10, 32'h100);
        push(5'd11, 32'h101);
        chk("pp start pending", 64'(pending), 64'd2);
        drain_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(5'(12 + i), 32'(32'h200 + i));
            chk("pp pending", 64'(pending), 64'd2);
        end
        wait_empty();

        // Reset in the middle of a drain
        drain_stall = 1'b1;
        push(5'd20, 32'hC0);
        push(5'd21, 32'hC1);
        push(5'd22, 32'hC2);
        chk("pre-reset pending", 64'(pending), 64'd3);
        drain_stall = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("midreset wr_ena", 64'(wr_ena), 64'd0);
        chk("midreset pending", 64'(pending), 64'd0);
        chk("midreset empty", 64'(empty), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) step();
        chk("post-reset pending", 64'(pending), 64'd0);
        chk("post-reset wr_ena", 64'(wr_ena), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
